fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 imem_req  output  1  SHALL indicate a fetch request to instruction memory.
REQ-005 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-006 imem_rvalid  input  1  SHALL mark the cycle in which imem_rdata holds the requested word.
REQ-007 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 redirect_valid  input  1  SHALL request a PC change (taken branch, jal, jalr).
REQ-009 redirect_pc  input  32  SHALL be the redirect target.
REQ-010 inst_valid  output  1  SHALL mark inst/inst_pc as valid for the decode controller.
REQ-011 inst  output  32  SHALL be the instruction presented to decode.
REQ-012 inst_pc  output  32  SHALL be the address of inst.
REQ-013 inst_ready  input  1  SHALL indicate decode accepts inst this cycle.
REQ-014 fetch_fault  output  1  SHALL flag a misaligned redirect.
REQ-015 fetch_count  output  32  SHALL count accepted instructions.

Function
REQ-016 FSM states SHALL be S_REQ, S_FLUSH, S_HOLD, S_FAULT; reset state S_REQ.
REQ-017 In S_REQ/S_FLUSH, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_rvalid; elsewhere imem_req SHALL be 0.
REQ-018 S_REQ with imem_rvalid and no redirect: latch inst=imem_rdata, inst_pc=pc; go S_HOLD; inst_valid SHALL rise the next cycle (1-cycle registered latency).
REQ-019 S_HOLD: inst, inst_pc SHALL remain stable while inst_valid && !inst_ready.
REQ-020 S_HOLD with inst_valid && inst_ready: pc SHALL become pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), inst_valid SHALL drop, state SHALL go S_REQ.
REQ-021 S_HOLD with redirect_valid (with or without inst_ready): the held instruction SHALL count as accepted if inst_ready=1, pc SHALL become redirect_pc, inst_valid SHALL drop, state SHALL go S_REQ.
REQ-022 S_REQ with redirect_valid and no imem_rvalid: target SHALL be latched, state SHALL go S_FLUSH; later redirects in S_FLUSH SHALL overwrite the latched target.
REQ-023 S_FLUSH on imem_rvalid: data SHALL be discarded, pc SHALL load latched target, state SHALL go S_REQ.
REQ-024 S_REQ with redirect_valid and imem_rvalid same cycle: data SHALL be discarded, pc SHALL load redirect_pc, state SHALL stay S_REQ with new address next cycle.
REQ-025 Any redirect with redirect_pc[1:0]!=0 SHALL, once no memory transaction is outstanding, enter S_FAULT; S_FAULT SHALL hold fetch_fault=1, imem_req=0, inst_valid=0 until reset.
REQ-026 fetch_count SHALL increment by 1 per inst_valid && inst_ready cycle, wrapping 32'hFFFF_FFFF to 0.
REQ-027 Peak throughput SHALL be one instruction per 3 cycles with 1-cycle memory (req, rvalid, hold).

Reset
REQ-028 On rst_n=0, immediately: pc=RESET_PC, state S_REQ, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, fetch_fault=0, fetch_count=0, latched target=0.
REQ-029 Reset mid-transaction SHALL abandon the outstanding fetch; first imem_req after release SHALL carry RESET_PC.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, NOP constant and default RESET_PC.
REQ-031 Single module; no sub-module needed.

Verification
REQ-032 Reset release, 1-cycle memory returning 32'h0000_0033, inst_ready=1 -> imem_addr 0,4,8; inst_valid every 3rd cycle; fetch_count=3 after 9 cycles.
REQ-033 inst_ready=0 for 5 cycles in S_HOLD -> inst, inst_pc unchanged, imem_req=0, fetch_count unchanged.
REQ-034 3-cycle memory, redirect_pc=32'h100 in S_REQ -> rdata discarded, next imem_addr=32'h100, no inst_valid for old word.
REQ-035 redirect with inst_ready in S_HOLD (pc=8, target 32'h40) -> fetch_count+1, next imem_addr=32'h40.
REQ-036 redirect_pc=32'h102 -> fetch_fault=1 after outstanding rvalid, imem_req=0 forever; rst_n=0 clears it.
REQ-037 rst_n pulsed low mid-S_REQ at pc=32'h20 -> outputs at reset values asynchronously; next imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch stage with redirect handling
// and a terminal fault state for misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  // Handshake: decode takes inst/inst_pc in any cycle where inst_valid && inst_ready
  // at the rising edge; inst/inst_pc never change while inst_valid && !inst_ready.
  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_target;
  logic         r_fault_pend;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic         r_inst_valid;
  logic         r_fault;
  logic [31:0]  r_count;

  logic w_accept;
  logic w_redir_bad;

  assign w_accept    = r_inst_valid & inst_ready;
  assign w_redir_bad = redirect_valid & is_misaligned(redirect_pc[1:0]);

  assign imem_req    = (r_state == S_REQ) || (r_state == S_FLUSH);
  assign imem_addr   = {r_pc[31:2], 2'b00};
  assign inst_valid  = r_inst_valid;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign fetch_fault = r_fault;
  assign fetch_count = r_count;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_target     <= 32'h0;
      r_fault_pend <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_count      <= 32'h0;
    end else begin
      if (w_accept) r_count <= r_count + 32'd1;
      case (r_state)
        S_REQ: begin
          if (redirect_valid) begin
            if (imem_rvalid) begin
              r_pc <= redirect_pc;
              if (w_redir_bad) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end
            end else begin
              // Memory still owes us a word; remember where to go once it lands.
              r_target     <= redirect_pc;
              r_fault_pend <= w_redir_bad;
              r_state      <= S_FLUSH;
            end
          end else if (imem_rvalid) begin
            r_inst       <= imem_rdata;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_FLUSH: begin
          if (redirect_valid) begin
            r_target     <= redirect_pc;
            r_fault_pend <= r_fault_pend | w_redir_bad;
          end
          if (imem_rvalid) begin
            r_pc <= redirect_valid ? redirect_pc : r_target;
            if (r_fault_pend | w_redir_bad) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_inst_valid <= 1'b0;
            r_pc         <= redirect_pc;
            if (w_redir_bad) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_pc         <= r_pc + 32'd4;
            r_state      <= S_REQ;
          end
        end
        S_FAULT: r_inst_valid <= 1'b0;
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
